pattern_count_engine: RTL and testbench
=======================================

# pattern_count_engine

Hardware responder for program 3 (5-bit pattern search). On a Start pulse it reads the pattern byte and the 32-byte search field from data memory. It counts pattern occurrences three ways, writes the three counts back to data memory, and holds Done high. It sits beside the data memory as a second memory master and answers the same req/done handshake the program-3 bench drives.

## Interface
Parameters:
- N_BYTES, 32: search field length in bytes, at addresses 0..N_BYTES-1.
- PAT_ADDR, 32: address of the pattern byte; the pattern is bits [7:3].
- RES_ADDR, 33: base address of the results. CTB goes to RES_ADDR, CTO to RES_ADDR+1, CTS to RES_ADDR+2.

Ports:
- Clk, input, 1: single clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high.
- Start, input, 1: request; sampled only in IDLE or DONE.
- Done, output, 1: high while in DONE.
- MemAddr, output, 8: data memory address.
- MemRdData, input, 8: data memory read data; combinational, valid in the same cycle as MemAddr.
- MemWrEn, output, 1: write strobe; the write occurs at the next Clk edge.
- MemWrData, output, 8: write data.

## Operation
- States: IDLE → RDPAT → SCAN → WR_CTB → WR_CTO → WR_CTS → DONE.
- IDLE:
  - MemWrEn=0, MemAddr=0.
  - Start=1 → RDPAT, and clear ctb, cto, cts, prev and idx.
- RDPAT (1 cycle): MemAddr=PAT_ADDR; latch pat = MemRdData[7:3].
- SCAN (N_BYTES cycles): MemAddr=idx, with cur = MemRdData.
  - In-byte windows: cur[7:3], cur[6:2], cur[5:1], cur[4:0].
    - ctb += number of these windows equal to pat (0..4).
    - cto += 1 if any of them matches.
  - Crossing windows, only when idx≥1: {prev[3:0],cur[7]}, {prev[2:0],cur[7:6]}, {prev[1:0],cur[7:5]}, {prev[0],cur[7:4]}.
  - cts += in-byte matches + crossing matches.
  - prev ← cur; idx ← idx+1. Leave SCAN after idx = N_BYTES-1.
- Window ordering:
  - Byte 0 is the most-significant byte of the string, and bit 7 is the first bit.
  - cts therefore equals the number of the 8·N_BYTES−4 bit-aligned windows across the whole string that equal pat.
- Writes, one cycle each with MemWrEn=1:
  - WR_CTB writes ctb to RES_ADDR.
  - WR_CTO writes cto to RES_ADDR+1.
  - WR_CTS writes cts to RES_ADDR+2.
- DONE:
  - Done=1, MemWrEn=0; hold the counts.
  - Start=1 → RDPAT, with all counters cleared and Done dropping the next cycle.
- Start in any other state is ignored.
- Arithmetic:
  - Counters are 8-bit unsigned. With N_BYTES=32 the maxima are ctb 128, cto 32 and cts 252, so no wrap occurs.
  - Per-cycle increments are computed as 3-bit sums before being added.
- Reset, in any state including mid-SCAN or mid-write:
  - Next state IDLE.
  - Done=0, MemWrEn=0, MemAddr=0.
  - ctb, cto, cts, pat, prev and idx all cleared.
  - No partial result write is issued after Reset is sampled.
  - Reset has priority over Start.

## Timing
- Reset values of outputs: Done=0, MemWrEn=0, MemWrData=0, MemAddr=0.
- Call the Start-sampling edge edge 0.
  - RDPAT occupies cycle 1.
  - SCAN occupies cycles 2..33.
  - Writes occupy cycles 34..36.
  - Done is high from cycle 37.
  - Total latency is N_BYTES+5 cycles.
- Memory results are valid in memory by the edge on which Done rises.
- Done is level, not a pulse. It stays high until a Reset or a new Start is sampled.
- MemWrEn is never high outside the three write states. Exactly three writes occur per run.
- Start held high continuously restarts the engine from DONE. Each run still completes fully.

## Test plan
- Memory all 0x00, pat=00000 → core[33]=128, core[34]=32, core[35]=252; Done at cycle 37.
- All bytes 0x55, pat=10101 → ctb=64, cto=32, cts=126.
- Memory all 0x00, pat=11111 → 0, 0, 0; exactly three write strobes observed.
- byte0=0x07, byte1=0xC0, rest 0x00, pat=11111 → ctb=0, cto=0, cts=1 (crossing-only match).
- Reset asserted at cycle 15 of SCAN, then restart with $random data → no writes before restart; final counts match a bench reference model identical to the program-3 checker.
- Start pulsed repeatedly during SCAN → ignored, latency unchanged. Second Start in DONE with new data → Done drops for one run, then the new counts are written.

Source files
------------

// File: rtl/pattern_count_engine_if.sv
// pattern_count_engine_if: start/done handshake and data memory port of the pattern counter
interface pattern_count_engine_if;
    logic       Start;
    logic       Done;
    logic [7:0] MemAddr;
    logic [7:0] MemRdData;
    logic       MemWrEn;
    logic [7:0] MemWrData;
    modport master (
        input  Start, MemRdData,
        output Done, MemAddr, MemWrEn, MemWrData
    );
    modport slave (
        output Start, MemRdData,
        input  Done, MemAddr, MemWrEn, MemWrData
    );
endinterface

// File: rtl/pattern_count_engine.sv
// pattern_count_engine: counts 5-bit pattern hits in a byte field and writes three counts to memory
module pattern_count_engine #(
    parameter int N_BYTES  = 32,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33
) (
    input logic Clk,
    input logic Reset,
    pattern_count_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, RDPAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
    logic [4:0] pat_q, pat_d;
    logic [7:0] prev_q, prev_d, idx_q, idx_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic       we_q, we_d, done_q, done_d;
    logic [7:0] cur;
    logic [3:0] in_hit, x_hit;
    logic [2:0] n_in, n_x;
    assign bus.MemAddr   = addr_q;
    assign bus.MemWrEn   = we_q;
    assign bus.MemWrData = wdata_q;
    assign bus.Done      = done_q;
    // Window matching for the current byte; outputs are registered, so each state sets up the next state's bus values
    always_comb begin
        cur    = bus.MemRdData;
        in_hit = {cur[7:3] == pat_q, cur[6:2] == pat_q, cur[5:1] == pat_q, cur[4:0] == pat_q};
        x_hit  = (idx_q != 8'd0) ? {{prev_q[3:0], cur[7]} == pat_q, {prev_q[2:0], cur[7:6]} == pat_q,
                                    {prev_q[1:0], cur[7:5]} == pat_q, {prev_q[0], cur[7:4]} == pat_q} : 4'b0;
        n_in   = {2'b0, in_hit[0]} + {2'b0, in_hit[1]} + {2'b0, in_hit[2]} + {2'b0, in_hit[3]};
        n_x    = {2'b0, x_hit[0]} + {2'b0, x_hit[1]} + {2'b0, x_hit[2]} + {2'b0, x_hit[3]};
        state_d = state_q;
        ctb_d   = ctb_q;
        cto_d   = cto_q;
        cts_d   = cts_q;
        pat_d   = pat_q;
        prev_d  = prev_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_d = RDPAT;
                    ctb_d   = 8'd0;
                    cto_d   = 8'd0;
                    cts_d   = 8'd0;
                    prev_d  = 8'd0;
                    idx_d   = 8'd0;
                    addr_d  = 8'(PAT_ADDR);
                    done_d  = 1'b0;
                end
            end
            RDPAT: begin
                pat_d   = cur[7:3];
                state_d = SCAN;
                addr_d  = 8'd0;
            end
            SCAN: begin
                ctb_d  = ctb_q + 8'(n_in);
                cto_d  = cto_q + {7'd0, |in_hit};
                cts_d  = cts_q + 8'(n_in) + 8'(n_x);
                prev_d = cur;
                idx_d  = idx_q + 8'd1;
                addr_d = idx_q + 8'd1;
                if (idx_q == 8'(N_BYTES - 1)) begin
                    state_d = WR_CTB;
                    addr_d  = 8'(RES_ADDR);
                    wdata_d = ctb_d;
                    we_d    = 1'b1;
                end
            end
            WR_CTB: begin
                state_d = WR_CTO;
                addr_d  = 8'(RES_ADDR + 1);
                wdata_d = cto_q;
                we_d    = 1'b1;
            end
            WR_CTO: begin
                state_d = WR_CTS;
                addr_d  = 8'(RES_ADDR + 2);
                wdata_d = cts_q;
                we_d    = 1'b1;
            end
            WR_CTS: begin
                state_d = DONE;
                addr_d  = 8'd0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and registered outputs; reset wins over everything, including a pending write
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ctb_q   <= 8'd0;
            cto_q   <= 8'd0;
            cts_q   <= 8'd0;
            pat_q   <= 5'd0;
            prev_q  <= 8'd0;
            idx_q   <= 8'd0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
            pat_q   <= pat_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_pattern_count_engine.sv
// tb_pattern_count_engine: directed checks of the pattern counter against a bit-string reference
module tb_pattern_count_engine;
    localparam int LAT = 36;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;
    pattern_count_engine_if bif();
    pattern_count_engine dut (.Clk(Clk), .Reset(Reset), .bus(bif.master));
    logic [7:0] mem [0:255];
    assign bif.MemRdData = mem[bif.MemAddr];
    int n_chk = 0;
    int n_pass = 0;
    int wr_cnt = 0;

    task automatic tick();
        logic       we;
        logic [7:0] a, d;
        we = bif.MemWrEn;
        a  = bif.MemAddr;
        d  = bif.MemWrData;
        @(posedge Clk);
        if (we) begin
            mem[a] = d;
            wr_cnt++;
        end
        #1;
    endtask

    task automatic model(output logic [7:0] b, output logic [7:0] o, output logic [7:0] s);
        logic [255:0] str;
        logic [4:0]   p;
        logic [31:0]  byte_hit;
        p = mem[32][7:3];
        for (int i = 0; i < 32; i++) str[255 - 8 * i -: 8] = mem[i];
        b = 0;
        s = 0;
        byte_hit = 0;
        for (int j = 0; j < 252; j++) begin
            if (str[255 - j -: 5] == p) begin
                s++;
                if (j % 8 <= 3) begin
                    b++;
                    byte_hit[j / 8] = 1'b1;
                end
            end
        end
        o = 8'($countones(byte_hit));
    endtask

    task automatic run(input bit pulse_mid, output int lat);
        bif.Start = 1'b1;
        tick();
        bif.Start = 1'b0;
        n_chk++;
        if (bif.Done !== 1'b0) $display("FAIL done_drop: Done=%b expected 0 after start edge", bif.Done);
        else n_pass++;
        lat = 0;
        while (bif.Done !== 1'b1 && lat < 100) begin
            bif.Start = pulse_mid && lat >= 2 && lat <= 20 && lat[0];
            tick();
            lat++;
        end
        bif.Start = 1'b0;
    endtask

    task automatic fill(input logic [7:0] v, input logic [7:0] pat_byte);
        for (int i = 0; i < 32; i++) mem[i] = v;
        mem[32] = pat_byte;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[32] = 8'($urandom);
    endtask

    task automatic check_res(input string name, input logic [7:0] b, input logic [7:0] o, input logic [7:0] s);
        n_chk++;
        if (mem[33] !== b) $display("FAIL %s_ctb: got %0d expected %0d", name, mem[33], b);
        else n_pass++;
        n_chk++;
        if (mem[34] !== o) $display("FAIL %s_cto: got %0d expected %0d", name, mem[34], o);
        else n_pass++;
        n_chk++;
        if (mem[35] !== s) $display("FAIL %s_cts: got %0d expected %0d", name, mem[35], s);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_chk++;
        if (bif.Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bif.Done);
        else n_pass++;
        n_chk++;
        if (bif.MemWrEn !== 1'b0) $display("FAIL reset_wren: got %b expected 0", bif.MemWrEn);
        else n_pass++;
        n_chk++;
        if (bif.MemAddr !== 8'd0) $display("FAIL reset_addr: got %0d expected 0", bif.MemAddr);
        else n_pass++;
        n_chk++;
        if (bif.MemWrData !== 8'd0) $display("FAIL reset_wdata: got %0d expected 0", bif.MemWrData);
        else n_pass++;
    endtask

    task automatic test_zeros();
        int lat, w0;
        fill(8'h00, 8'h00);
        w0 = wr_cnt;
        run(1'b0, lat);
        n_chk++;
        if (lat !== LAT) $display("FAIL zeros_latency: got %0d expected %0d", lat, LAT);
        else n_pass++;
        check_res("zeros", 8'd128, 8'd32, 8'd252);
        n_chk++;
        if (wr_cnt - w0 !== 3) $display("FAIL zeros_writes: got %0d expected 3", wr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_alternating();
        int lat;
        fill(8'h55, 8'hA8);
        run(1'b0, lat);
        check_res("alt", 8'd64, 8'd32, 8'd126);
    endtask

    task automatic test_no_match();
        int lat, w0;
        fill(8'h00, 8'hF8);
        w0 = wr_cnt;
        run(1'b0, lat);
        check_res("nomatch", 8'd0, 8'd0, 8'd0);
        n_chk++;
        if (wr_cnt - w0 !== 3) $display("FAIL nomatch_writes: got %0d expected 3", wr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_crossing();
        int lat;
        fill(8'h00, 8'hF8);
        mem[0] = 8'h07;
        mem[1] = 8'hC0;
        run(1'b0, lat);
        check_res("cross", 8'd0, 8'd0, 8'd1);
    endtask

    task automatic test_reset_mid_scan();
        int lat, w0;
        logic [7:0] b, o, s;
        fill_rand();
        mem[33] = 8'hEE;
        mem[34] = 8'hEE;
        mem[35] = 8'hEE;
        bif.Start = 1'b1;
        tick();
        bif.Start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        w0 = wr_cnt;
        Reset = 1'b1;
        bif.Start = 1'b1;
        tick();
        Reset = 1'b0;
        bif.Start = 1'b0;
        n_chk++;
        if (bif.MemAddr !== 8'd0) $display("FAIL midrst_addr: got %0d expected 0", bif.MemAddr);
        else n_pass++;
        for (int i = 0; i < 45; i++) tick();
        n_chk++;
        if (wr_cnt - w0 !== 0) $display("FAIL midrst_writes: got %0d expected 0", wr_cnt - w0);
        else n_pass++;
        n_chk++;
        if (bif.Done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bif.Done);
        else n_pass++;
        n_chk++;
        if (mem[33] !== 8'hEE) $display("FAIL midrst_untouched: got %0h expected ee", mem[33]);
        else n_pass++;
        fill_rand();
        model(b, o, s);
        w0 = wr_cnt;
        run(1'b0, lat);
        check_res("midrst", b, o, s);
        n_chk++;
        if (wr_cnt - w0 !== 3) $display("FAIL midrst_rerun_writes: got %0d expected 3", wr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_start_during_scan();
        int lat;
        logic [7:0] b, o, s;
        fill_rand();
        model(b, o, s);
        run(1'b1, lat);
        n_chk++;
        if (lat !== LAT) $display("FAIL midstart_latency: got %0d expected %0d", lat, LAT);
        else n_pass++;
        check_res("midstart", b, o, s);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] b, o, s;
        for (int i = 0; i < 3; i++) tick();
        n_chk++;
        if (bif.Done !== 1'b1) $display("FAIL b2b_done_held: got %b expected 1", bif.Done);
        else n_pass++;
        fill_rand();
        model(b, o, s);
        run(1'b0, lat);
        n_chk++;
        if (lat !== LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT);
        else n_pass++;
        check_res("b2b", b, o, s);
    endtask

    initial begin
        bif.Start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        test_reset();
        Reset = 1'b0;
        tick();
        test_zeros();
        test_alternating();
        test_no_match();
        test_crossing();
        test_reset_mid_scan();
        test_start_during_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
